systolic_job_scheduler: RTL and testbench
=========================================

// Module: systolic_job_scheduler
// PURPOSE
//   Two-requester job scheduler for the 2x2 systolic array. It arbitrates round-robin between
//   two requesters. It latches one A/B operand job, clears the array and drives its inputs
//   until a result appears. It then returns C to the winning requester on a valid/ready
//   response channel tagged with the requester id.
// PARAMETERS
//   DATA_WIDTH      4   operand element width (matches array)
//   ACC_WIDTH       9   result element width (matches array)
//   TIMEOUT_CYCLES  16  max RUN cycles before abort (used only with SCHED_TIMEOUT_EN)
// PORTS
//   clk            in   1             clock, all logic on posedge
//   rst            in   1             reset, synchronous, active-high
//   req_valid      in   2             per-requester job valid
//   req_ready      out  2             per-requester accept; at most one bit set
//   req_a0/req_a1  in   4*DATA_WIDTH  A of requester 0/1, packed {a11,a10,a01,a00}, a00 in LSBs
//   req_b0/req_b1  in   4*DATA_WIDTH  B of requester 0/1, same packing
//   rsp_valid      out  1             response valid
//   rsp_ready      in   1             response accept
//   rsp_id         out  1             requester that owns the response
//   rsp_c          out  4*ACC_WIDTH   result {c11,c10,c01,c00}
//   rsp_err        out  1             1 = aborted job, rsp_c is zero
//   arr_rstn       out  1             array reset (active-low)
//   arr_in_valid   out  1             array in_valid
//   arr_a/arr_b    out  4*DATA_WIDTH  latched operands to the array, same packing
//   arr_out_valid  in   1             array out_valid
//   arr_c          in   4*ACC_WIDTH   array {c11,c10,c01,c00}
// BEHAVIOUR
//   - Reset (rst=1 at posedge): state=IDLE, rr_last=1 (requester 0 wins first), req_ready=0,
//     rsp_valid=0, rsp_id=0, rsp_c=0, rsp_err=0, arr_in_valid=0, arr_a=arr_b=0, run_cnt=0.
//     arr_rstn = ~(rst | state==FLUSH), combinational; it is low throughout rst.
//   - IDLE: req_ready[i]=1 combinationally for the granted i only.
//     Grant = the sole valid requester; if both are valid, the one != rr_last.
//     On accept (req_valid[i] & req_ready[i]): latch A/B into arr_a/arr_b, set rsp_id=i,
//     set rr_last=i, go to FLUSH.
//   - FLUSH (1 cycle): arr_rstn=0 clears the array's internal counters, arr_in_valid=0.
//     Next state is RUN.
//   - RUN: arr_in_valid=1 and operands held stable; run_cnt increments each cycle.
//     On the first cycle with arr_out_valid=1: register arr_c into rsp_c, rsp_err=0,
//     arr_in_valid=0 next cycle, go to RESP.
//     arr_out_valid seen outside RUN is ignored.
//   - RESP: rsp_valid=1. rsp_c, rsp_id and rsp_err hold until rsp_valid & rsp_ready.
//     Then go to IDLE with rsp_valid=0 next cycle. No new job is accepted while in RESP.
//   - Latency: accept at cycle T -> FLUSH at T+1 -> arr_in_valid first high at T+2.
//     rsp_valid rises the cycle after the first RUN cycle with arr_out_valid=1.
//   - Back-to-back: the earliest next accept is the cycle after the response handshake.
//     Dropping req_valid without a handshake has no effect.
//   - rst mid-operation (any state): return to IDLE per reset values. The in-flight job
//     and any pending response are discarded; no rsp_valid is produced for them.
//   - run_cnt is clog2(TIMEOUT_CYCLES+1) bits wide, clears on entry to RUN and saturates.
//     Results pass through unmodified at ACC_WIDTH; no truncation or sign handling.
// CONFIGURATION
//   SCHED_TIMEOUT_EN defined:
//     - In RUN, when run_cnt reaches TIMEOUT_CYCLES with no arr_out_valid: go to RESP with
//       rsp_err=1 and rsp_c=0.
//     - If arr_out_valid=1 on the same cycle, the valid result wins (rsp_err=0).
//   SCHED_TIMEOUT_EN undefined: RUN waits indefinitely; rsp_err is tied 0; TIMEOUT_CYCLES unused.
// TESTING
//   1. req0 A={4,3,2,1}, B={1,0,0,1} (identity) -> rsp_valid with rsp_id=0,
//      rsp_c={4,3,2,1}, rsp_err=0; arr_in_valid first high 2 cycles after accept.
//   2. A=B=all 15 -> rsp_c={450,450,450,450}, no overflow at ACC_WIDTH=9.
//   3. Both req_valid high, two jobs each, from reset -> grant order 0,1,0,1;
//      req_ready never has 2 bits set.
//   4. rsp_ready held 0 for 5 cycles in RESP -> rsp_valid/rsp_c/rsp_id stable;
//      req_ready=0 throughout; IDLE the cycle after the handshake.
//   5. (SCHED_TIMEOUT_EN) arr_out_valid stuck 0 -> after 16 RUN cycles rsp_err=1, rsp_c=0.
//      Without the macro, the block stays in RUN.
//   6. rst pulsed during RUN -> next cycle all outputs at reset values, arr_rstn=0 during rst.
//      The next job completes correctly with requester 0 granted first.

Source files
------------

// File: rtl/systolic_job_scheduler_if.sv
// Request, response and array-side signal bundle of the systolic job scheduler.
// slave = scheduler side, master = requesters plus array side.
interface systolic_job_scheduler_if #(
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned ACC_WIDTH  = 9
);
  localparam int unsigned OP_W  = 4 * DATA_WIDTH;
  localparam int unsigned RES_W = 4 * ACC_WIDTH;

  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [OP_W-1:0]  req_a0;
  logic [OP_W-1:0]  req_a1;
  logic [OP_W-1:0]  req_b0;
  logic [OP_W-1:0]  req_b1;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [RES_W-1:0] rsp_c;
  logic             rsp_err;
  logic             arr_rstn;
  logic             arr_in_valid;
  logic [OP_W-1:0]  arr_a;
  logic [OP_W-1:0]  arr_b;
  logic             arr_out_valid;
  logic [RES_W-1:0] arr_c;

  modport slave (
    input  req_valid, req_a0, req_a1, req_b0, req_b1, rsp_ready, arr_out_valid, arr_c,
    output req_ready, rsp_valid, rsp_id, rsp_c, rsp_err, arr_rstn, arr_in_valid, arr_a, arr_b
  );

  modport master (
    output req_valid, req_a0, req_a1, req_b0, req_b1, rsp_ready, arr_out_valid, arr_c,
    input  req_ready, rsp_valid, rsp_id, rsp_c, rsp_err, arr_rstn, arr_in_valid, arr_a, arr_b
  );
endinterface

// File: rtl/systolic_job_scheduler.sv
// Round-robin two-requester job scheduler feeding a 2x2 systolic array.
// Optional RUN timeout abort is enabled with `define SCHED_TIMEOUT_EN.
module systolic_job_scheduler #(
  parameter int unsigned DATA_WIDTH     = 4,
  parameter int unsigned ACC_WIDTH      = 9,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  systolic_job_scheduler_if.slave bus
);
  localparam int unsigned OP_W  = 4 * DATA_WIDTH;
  localparam int unsigned RES_W = 4 * ACC_WIDTH;
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, FLUSH, RUN, RESP} state_t;

  state_t           state;
  state_t           state_next;
  logic             rr_last;
  logic [CNT_W-1:0] run_cnt;
  logic             grant_c;
  logic             accept_c;
  logic             timeout_c;
  logic [OP_W-1:0]  a_sel_c;
  logic [OP_W-1:0]  b_sel_c;

  // Sole valid requester wins; on contention the one not served last.
  assign grant_c = bus.req_valid[1] & (~bus.req_valid[0] | ~rr_last);
  assign a_sel_c = grant_c ? bus.req_a1 : bus.req_a0;
  assign b_sel_c = grant_c ? bus.req_b1 : bus.req_b0;

  assign bus.arr_rstn = ~(rst | (state == FLUSH));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next    = state;
    accept_c      = 1'b0;
    timeout_c     = 1'b0;
    bus.req_ready = 2'b00;
    case (state)
      IDLE: begin
        if (!rst && (bus.req_valid != 2'b00)) begin
          bus.req_ready = grant_c ? 2'b10 : 2'b01;
          accept_c      = 1'b1;
          state_next    = FLUSH;
        end
      end
      FLUSH: state_next = RUN;
      RUN: begin
`ifdef SCHED_TIMEOUT_EN
        timeout_c = (run_cnt >= CNT_W'(TIMEOUT_CYCLES - 1));
`else
        timeout_c = 1'b0;
`endif
        if (bus.arr_out_valid || timeout_c) state_next = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Job latch, response capture and array drive.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_last          <= 1'b1;
      run_cnt          <= '0;
      bus.rsp_valid    <= 1'b0;
      bus.rsp_id       <= 1'b0;
      bus.rsp_c        <= '0;
      bus.rsp_err      <= 1'b0;
      bus.arr_in_valid <= 1'b0;
      bus.arr_a        <= '0;
      bus.arr_b        <= '0;
    end else begin
      bus.arr_in_valid <= (state_next == RUN);
      bus.rsp_valid    <= (state_next == RESP);
      if (accept_c) begin
        bus.arr_a  <= a_sel_c;
        bus.arr_b  <= b_sel_c;
        bus.rsp_id <= grant_c;
        rr_last    <= grant_c;
      end
      if (state == FLUSH) begin
        run_cnt <= '0;
      end else if ((state == RUN) && (run_cnt != '1)) begin
        run_cnt <= run_cnt + CNT_W'(1);
      end
      // A real result beats a timeout landing on the same cycle.
      if ((state == RUN) && (state_next == RESP)) begin
        bus.rsp_c   <= bus.arr_out_valid ? bus.arr_c : RES_W'(0);
        bus.rsp_err <= timeout_c & ~bus.arr_out_valid;
      end
    end
  end
endmodule

// File: tb/tb_systolic_job_scheduler.sv
// Self-checking bench for systolic_job_scheduler with a behavioural 2x2 array and scheduler model.
// Follows the build's SCHED_TIMEOUT_EN setting.
module tb_systolic_job_scheduler;
  localparam int unsigned DW = 4;
  localparam int unsigned AW = 9;
  localparam int unsigned TO = 16;

  logic clk = 1'b0;
  logic rst;

  systolic_job_scheduler_if #(.DATA_WIDTH(DW), .ACC_WIDTH(AW)) bus ();

  systolic_job_scheduler #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int model_rr_last = 1;
  int arr_lat = 1;
  bit arr_stuck = 1'b0;
  int arr_cnt = 0;

  function automatic logic [35:0] ref_matmul(input logic [15:0] a, input logic [15:0] b);
    logic [35:0] c;
    int s;
    c = '0;
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        s = 0;
        for (int k = 0; k < 2; k++)
          s += int'(a[(i*2+k)*4 +: 4]) * int'(b[(k*2+j)*4 +: 4]);
        c[(i*2+j)*9 +: 9] = 9'(s);
      end
    end
    return c;
  endfunction

  function automatic int model_grant(input logic [1:0] v);
    if (v == 2'b11) return (model_rr_last == 0) ? 1 : 0;
    return v[1] ? 1 : 0;
  endfunction

  // Array stand-in: counts in_valid cycles since its reset, then presents A*B; noise when idle.
  always @(negedge clk) begin
    if (bus.arr_rstn !== 1'b1) begin
      arr_cnt = 0;
      bus.arr_out_valid = 1'b0;
      bus.arr_c = 36'({$urandom(), $urandom()});
    end else if (bus.arr_in_valid === 1'b1) begin
      arr_cnt++;
      if (!arr_stuck && arr_cnt >= arr_lat) begin
        bus.arr_out_valid = 1'b1;
        bus.arr_c = ref_matmul(bus.arr_a, bus.arr_b);
      end else begin
        bus.arr_out_valid = 1'b0;
        bus.arr_c = 36'({$urandom(), $urandom()});
      end
    end else begin
      bus.arr_out_valid = 1'($urandom_range(0, 1));
      bus.arr_c = 36'({$urandom(), $urandom()});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid = 2'b00;
    bus.rsp_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    model_rr_last = 1;
  endtask

  // Entered 1 unit after an edge with the DUT in IDLE; leaves 1 unit into the first RUN cycle.
  task automatic start_job(input logic [1:0] v, input logic [15:0] a0, input logic [15:0] b0,
                           input logic [15:0] a1, input logic [15:0] b1, input int lat,
                           output int g);
    logic [15:0] ea;
    logic [15:0] eb;
    arr_lat = lat;
    bus.req_valid = v;
    bus.req_a0 = a0; bus.req_b0 = b0; bus.req_a1 = a1; bus.req_b1 = b1;
    #1;
    g = model_grant(v);
    ea = (g == 1) ? a1 : a0;
    eb = (g == 1) ? b1 : b0;
    checks++;
    if (bus.req_ready !== ((g == 1) ? 2'b10 : 2'b01))
      $display("FAIL grant req_ready got=%b exp=%b", bus.req_ready, (g == 1) ? 2'b10 : 2'b01);
    else passes++;
    tick();
    model_rr_last = g;
    bus.req_valid = 2'b00;
    bus.req_a0 = 16'($urandom()); bus.req_b0 = 16'($urandom());
    bus.req_a1 = 16'($urandom()); bus.req_b1 = 16'($urandom());
    #1;
    checks++;
    if ({bus.arr_rstn, bus.arr_in_valid, bus.req_ready, bus.rsp_id, bus.arr_a, bus.arr_b}
        !== {1'b0, 1'b0, 2'b00, 1'(g), ea, eb})
      $display("FAIL flush got rstn=%b iv=%b rdy=%b id=%b a=%h b=%h exp a=%h b=%h id=%0d",
               bus.arr_rstn, bus.arr_in_valid, bus.req_ready, bus.rsp_id, bus.arr_a, bus.arr_b,
               ea, eb, g);
    else passes++;
    tick();
    checks++;
    if ({bus.arr_rstn, bus.arr_in_valid, bus.arr_a, bus.arr_b} !== {1'b1, 1'b1, ea, eb})
      $display("FAIL run_start got rstn=%b iv=%b a=%h b=%h exp iv=1 a=%h b=%h",
               bus.arr_rstn, bus.arr_in_valid, bus.arr_a, bus.arr_b, ea, eb);
    else passes++;
  endtask

  task automatic wait_resp(input int exp_runs);
    int runs = 0;
    int guard = 0;
    while (bus.rsp_valid !== 1'b1 && guard < 200) begin
      if (bus.arr_in_valid === 1'b1) runs++;
      tick();
      guard++;
    end
    checks++;
    if (guard >= 200) $display("FAIL rsp_wait got=no rsp_valid exp=rsp_valid within 200 cycles");
    else if (runs != exp_runs) $display("FAIL run_cycles got=%0d exp=%0d", runs, exp_runs);
    else passes++;
  endtask

  // Entered in the first RESP cycle; leaves 1 unit into the IDLE cycle after the handshake.
  task automatic finish_resp(input logic [35:0] exp_c, input logic exp_id, input logic exp_err,
                             input int hold, input bit poke);
    bit bad = 1'b0;
    checks++;
    if ({bus.rsp_valid, bus.rsp_id, bus.rsp_err, bus.rsp_c, bus.arr_in_valid}
        !== {1'b1, exp_id, exp_err, exp_c, 1'b0})
      $display("FAIL resp got v=%b id=%b err=%b c=%h iv=%b exp id=%b err=%b c=%h",
               bus.rsp_valid, bus.rsp_id, bus.rsp_err, bus.rsp_c, bus.arr_in_valid,
               exp_id, exp_err, exp_c);
    else passes++;
    for (int i = 0; i < hold; i++) begin
      bus.rsp_ready = 1'b0;
      if (poke) bus.req_valid = 2'b11;
      #1;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_c !== exp_c || bus.rsp_id !== exp_id ||
          bus.rsp_err !== exp_err || bus.req_ready !== 2'b00) bad = 1'b1;
      tick();
    end
    if (hold > 0) begin
      checks++;
      if (bad) $display("FAIL resp_hold got=unstable or req_ready set exp=stable for %0d cycles", hold);
      else passes++;
    end
    bus.req_valid = 2'b00;
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    checks++;
    if ({bus.rsp_valid, bus.arr_in_valid, bus.arr_rstn} !== 3'b001)
      $display("FAIL after_handshake got v=%b iv=%b rstn=%b exp=0 0 1",
               bus.rsp_valid, bus.arr_in_valid, bus.arr_rstn);
    else passes++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = 2'b00; bus.rsp_ready = 1'b0;
    bus.req_a0 = '0; bus.req_a1 = '0; bus.req_b0 = '0; bus.req_b1 = '0;
    repeat (3) tick();
    checks++;
    if ({bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_c, bus.rsp_err, bus.arr_in_valid,
         bus.arr_a, bus.arr_b, bus.arr_rstn} !== 75'd0)
      $display("FAIL reset_values got rdy=%b v=%b id=%b c=%h err=%b iv=%b a=%h b=%h rstn=%b exp=all 0",
               bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_c, bus.rsp_err,
               bus.arr_in_valid, bus.arr_a, bus.arr_b, bus.arr_rstn);
    else passes++;
    rst = 1'b0;
    model_rr_last = 1;
    tick();
    checks++;
    if ({bus.arr_rstn, bus.req_ready, bus.rsp_valid} !== 4'b1000)
      $display("FAIL reset_release got rstn=%b rdy=%b v=%b exp=1 00 0",
               bus.arr_rstn, bus.req_ready, bus.rsp_valid);
    else passes++;
  endtask

  task automatic test_identity();
    int g;
    start_job(2'b01, {4'd4, 4'd3, 4'd2, 4'd1}, {4'd1, 4'd0, 4'd0, 4'd1}, 16'hFFFF, 16'hFFFF, 3, g);
    wait_resp(3);
    finish_resp({9'd4, 9'd3, 9'd2, 9'd1}, 1'b0, 1'b0, 0, 1'b0);
  endtask

  task automatic test_max_values();
    int g;
    start_job(2'b10, 16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF, 2, g);
    wait_resp(2);
    finish_resp({9'd450, 9'd450, 9'd450, 9'd450}, 1'b1, 1'b0, 0, 1'b0);
  endtask

  task automatic test_round_robin();
    int g;
    logic [15:0] a0, b0, a1, b1;
    int lat;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      a0 = 16'($urandom()); b0 = 16'($urandom()); a1 = 16'($urandom()); b1 = 16'($urandom());
      lat = $urandom_range(1, 6);
      start_job(2'b11, a0, b0, a1, b1, lat, g);
      wait_resp(lat);
      finish_resp((i % 2 == 1) ? ref_matmul(a1, b1) : ref_matmul(a0, b0), 1'(i % 2), 1'b0, 0, 1'b0);
    end
  endtask

  task automatic test_backpressure();
    int g;
    logic [15:0] a, b;
    a = 16'($urandom()); b = 16'($urandom());
    start_job(2'b01, a, b, 16'h0, 16'h0, 1, g);
    wait_resp(1);
    finish_resp(ref_matmul(a, b), 1'b0, 1'b0, 5, 1'b1);
  endtask

  task automatic test_back_to_back();
    int g;
    logic [15:0] a, b;
    for (int i = 0; i < 3; i++) begin
      a = 16'($urandom()); b = 16'($urandom());
      start_job(2'b10, 16'h0, 16'h0, a, b, 1, g);
      wait_resp(1);
      finish_resp(ref_matmul(a, b), 1'b1, 1'b0, 0, 1'b0);
    end
  endtask

  task automatic test_drop_valid();
    bus.req_valid = 2'b01;
    #1;
    bus.req_valid = 2'b00;
    tick();
    checks++;
    if ({bus.arr_rstn, bus.arr_in_valid, bus.rsp_valid} !== 3'b100)
      $display("FAIL drop_valid got rstn=%b iv=%b v=%b exp=1 0 0",
               bus.arr_rstn, bus.arr_in_valid, bus.rsp_valid);
    else passes++;
  endtask

  task automatic test_random();
    int g, lat, hold;
    logic [1:0] v;
    logic [15:0] a0, b0, a1, b1;
    for (int i = 0; i < 20; i++) begin
      case ($urandom_range(0, 2))
        0: v = 2'b01;
        1: v = 2'b10;
        default: v = 2'b11;
      endcase
      a0 = 16'($urandom()); b0 = 16'($urandom()); a1 = 16'($urandom()); b1 = 16'($urandom());
      lat = $urandom_range(1, 6);
      hold = $urandom_range(0, 3);
      start_job(v, a0, b0, a1, b1, lat, g);
      wait_resp(lat);
      finish_resp((g == 1) ? ref_matmul(a1, b1) : ref_matmul(a0, b0), 1'(g), 1'b0, hold,
                  1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_timeout();
    int g;
    logic [15:0] a, b;
`ifdef SCHED_TIMEOUT_EN
    arr_stuck = 1'b1;
    start_job(2'b01, 16'hFFFF, 16'hFFFF, 16'h0, 16'h0, 1, g);
    wait_resp(TO);
    finish_resp(36'd0, 1'b0, 1'b1, 0, 1'b0);
    arr_stuck = 1'b0;
    a = 16'($urandom()); b = 16'($urandom());
    start_job(2'b10, 16'h0, 16'h0, a, b, TO, g);
    wait_resp(TO);
    finish_resp(ref_matmul(a, b), 1'b1, 1'b0, 0, 1'b0);
`else
    bit bad = 1'b0;
    arr_stuck = 1'b1;
    a = 16'($urandom()); b = 16'($urandom());
    start_job(2'b01, a, b, 16'h0, 16'h0, 1, g);
    for (int i = 0; i < 40; i++) begin
      if (bus.arr_in_valid !== 1'b1 || bus.rsp_valid !== 1'b0) bad = 1'b1;
      tick();
    end
    checks++;
    if (bad) $display("FAIL no_timeout got=left RUN exp=stay in RUN for 40 cycles");
    else passes++;
    arr_stuck = 1'b0;
    do_reset();
`endif
  endtask

  task automatic test_reset_mid_run();
    int g;
    bit bad = 1'b0;
    logic [15:0] a0, b0, a1, b1;
    start_job(2'b10, 16'h0, 16'h0, 16'h1111, 16'h1111, 1, g);
    wait_resp(1);
    finish_resp({9'd2, 9'd2, 9'd2, 9'd2}, 1'b1, 1'b0, 0, 1'b0);
    start_job(2'b10, 16'h0, 16'h0, 16'h2222, 16'h3333, 50, g);
    tick();
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if (bus.arr_rstn !== 1'b0) $display("FAIL rst_arr_rstn got=%b exp=0", bus.arr_rstn);
    else passes++;
    tick();
    checks++;
    if ({bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_c, bus.rsp_err, bus.arr_in_valid,
         bus.arr_a, bus.arr_b, bus.arr_rstn} !== 75'd0)
      $display("FAIL mid_run_reset got rdy=%b v=%b id=%b c=%h err=%b iv=%b a=%h b=%h rstn=%b exp=all 0",
               bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_c, bus.rsp_err,
               bus.arr_in_valid, bus.arr_a, bus.arr_b, bus.arr_rstn);
    else passes++;
    rst = 1'b0;
    model_rr_last = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.rsp_valid !== 1'b0 || bus.arr_in_valid !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) $display("FAIL discarded_job got=activity after reset exp=idle");
    else passes++;
    a0 = 16'($urandom()); b0 = 16'($urandom()); a1 = 16'($urandom()); b1 = 16'($urandom());
    start_job(2'b11, a0, b0, a1, b1, 2, g);
    wait_resp(2);
    finish_resp(ref_matmul(a0, b0), 1'b0, 1'b0, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_identity();
    test_max_values();
    test_drop_valid();
    test_round_robin();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_timeout();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
